// File: rtl/wave_gen_cordic_nco.sv
// wave_gen_cordic_nco: NCH phase accumulators sharing one iterative
// rotation-mode CORDIC. Each sample takes one LOAD cycle (quadrant fold and
// accumulator advance), NITER micro-rotations, and one DONE cycle in which
// the registered sin/cos and the channel tag are presented with o_valid.
module wave_gen_cordic_nco #(
  parameter int NCH   = 2,
  parameter int PW    = 16,
  parameter int OW    = 16,
  parameter int NITER = 14,
  parameter int GW    = 2,
  localparam int CW   = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  i_sync,
  input  logic [NCH*PW-1:0]     i_phi,
  output logic signed [OW-1:0]  cos,
  output logic signed [OW-1:0]  sin,
  output logic                  o_valid,
  output logic [CW-1:0]         o_ch
);

  // x/y carry the guard bits plus headroom for the CORDIC gain overshoot.
  localparam int  XW     = OW + GW + 2;
  localparam int  XW1    = XW + 1;
  // Phase sums (acc + inc) need one bit more than the phase itself.
  localparam int  ZW     = PW + 1;
  localparam int  IW     = $clog2(NITER + 1);
  localparam real ASCALE = 2.0 ** (PW - 3);
  localparam int  PI_I   = $rtoi(3.14159265358979 * ASCALE + 0.5);
  localparam int  HPI_I  = $rtoi(1.57079632679490 * ASCALE + 0.5);

  localparam logic signed [ZW-1:0]  PI_Z     = ZW'(PI_I);
  localparam logic signed [ZW-1:0]  NPI_Z    = ZW'(-PI_I);
  localparam logic signed [ZW-1:0]  TWO_PI_Z = ZW'(2 * PI_I);
  localparam logic signed [ZW-1:0]  HPI_Z    = ZW'(HPI_I);
  localparam logic signed [ZW-1:0]  NHPI_Z   = ZW'(-HPI_I);
  localparam logic signed [XW-1:0]  X_INIT   = XW'($rtoi(0.6072529350 * (2.0 ** (OW - 2 + GW)) + 0.5));
  localparam logic signed [XW1-1:0] OMAX     = XW1'(2 ** (OW - 2));
  localparam logic signed [XW1-1:0] OMIN     = XW1'(-(2 ** (OW - 2)));
  localparam logic signed [XW1-1:0] RND      = XW1'((GW > 0) ? (2 ** (GW - 1)) : 0);
  localparam logic [CW-1:0]         LAST_CH  = CW'(NCH - 1);
  localparam logic [IW-1:0]         LAST_IT  = IW'(NITER - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_ITER, S_DONE} state_t;

  // Rounded atan(2^-i) in phase units; only ever evaluated with constant i.
  function automatic logic signed [ZW-1:0] atan_entry(input int i);
    real r;
    r = $atan(1.0 / (2.0 ** i)) * ASCALE;
    return ZW'($rtoi(r + 0.5));
  endfunction

  // Undo the quadrant fold, drop guard bits (round half up), clamp to +/-1.0.
  function automatic logic signed [OW-1:0] fmt_out(input logic signed [XW-1:0] v,
                                                   input logic neg);
    logic signed [XW1-1:0] vn;
    logic signed [XW1-1:0] vr;
    logic signed [OW-1:0]  res;
    vn = neg ? -{v[XW-1], v} : {v[XW-1], v};
    vr = (vn + RND) >>> GW;
    if (vr > OMAX) begin
      res = OMAX[OW-1:0];
    end else if (vr < OMIN) begin
      res = OMIN[OW-1:0];
    end else begin
      res = vr[OW-1:0];
    end
    return res;
  endfunction

  logic signed [ZW-1:0] atan_tab [NITER];
  for (genvar g = 0; g < NITER; g++) begin : g_atan
    assign atan_tab[g] = atan_entry(g);
  end

  state_t               state_q;
  logic [CW-1:0]        ptr_q;
  logic signed [PW-1:0] acc_q [NCH];
  logic signed [XW-1:0] x_q, y_q;
  logic signed [ZW-1:0] z_q;
  logic                 neg_q;
  logic [IW-1:0]        it_q;
  logic signed [OW-1:0] cos_q, sin_q;
  logic                 valid_q;
  logic [CW-1:0]        ch_q;

  logic signed [PW-1:0] phi_s;
  logic signed [ZW-1:0] a_ext, inc_ext, inc_sat, sum_s, z_ld;
  logic                 neg_ld;
  logic signed [PW-1:0] acc_d;
  logic signed [XW-1:0] x_sh, y_sh, x_d, y_d;
  logic signed [ZW-1:0] atan_s, z_d;

  // LOAD-stage arithmetic: fold the sampled phase, saturate the increment,
  // advance the accumulator and wrap it back into [-PI, PI].
  always_comb begin
    phi_s   = i_phi[int'(ptr_q) * PW +: PW];
    a_ext   = {acc_q[ptr_q][PW-1], acc_q[ptr_q]};
    inc_ext = {phi_s[PW-1], phi_s};
    if (inc_ext > PI_Z) begin
      inc_sat = PI_Z;
    end else if (inc_ext < NPI_Z) begin
      inc_sat = NPI_Z;
    end else begin
      inc_sat = inc_ext;
    end
    sum_s = a_ext + inc_sat;
    if (sum_s > PI_Z) begin
      acc_d = PW'(sum_s - TWO_PI_Z);
    end else if (sum_s < NPI_Z) begin
      acc_d = PW'(sum_s + TWO_PI_Z);
    end else begin
      acc_d = PW'(sum_s);
    end
    if (a_ext > HPI_Z) begin
      z_ld   = a_ext - PI_Z;
      neg_ld = 1'b1;
    end else if (a_ext < NHPI_Z) begin
      z_ld   = a_ext + PI_Z;
      neg_ld = 1'b1;
    end else begin
      z_ld   = a_ext;
      neg_ld = 1'b0;
    end
  end

  // One CORDIC micro-rotation driving z toward zero (z >= 0 rotates positive).
  always_comb begin
    x_sh   = x_q >>> it_q;
    y_sh   = y_q >>> it_q;
    atan_s = atan_tab[it_q];
    if (!z_q[ZW-1]) begin
      x_d = x_q - y_sh;
      y_d = y_q + x_sh;
      z_d = z_q - atan_s;
    end else begin
      x_d = x_q + y_sh;
      y_d = y_q - x_sh;
      z_d = z_q + atan_s;
    end
  end

  // Sequencer and datapath registers; sync aborts any sample in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      neg_q   <= 1'b0;
      it_q    <= '0;
      cos_q   <= '0;
      sin_q   <= '0;
      valid_q <= 1'b0;
      ch_q    <= '0;
    end else if (i_sync) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (en) state_q <= S_LOAD;
        end
        S_LOAD: begin
          acc_q[ptr_q] <= acc_d;
          x_q          <= X_INIT;
          y_q          <= '0;
          z_q          <= z_ld;
          neg_q        <= neg_ld;
          it_q         <= '0;
          state_q      <= S_ITER;
        end
        S_ITER: begin
          x_q  <= x_d;
          y_q  <= y_d;
          z_q  <= z_d;
          it_q <= it_q + IW'(1);
          if (it_q == LAST_IT) begin
            // Final rotation: results land in the output registers so that
            // o_valid coincides with the DONE cycle.
            cos_q   <= fmt_out(x_d, neg_q);
            sin_q   <= fmt_out(y_d, neg_q);
            ch_q    <= ptr_q;
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          ptr_q   <= (ptr_q == LAST_CH) ? '0 : ptr_q + CW'(1);
          state_q <= en ? S_LOAD : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign cos     = cos_q;
  assign sin     = sin_q;
  assign o_valid = valid_q;
  assign o_ch    = ch_q;

endmodule

// File: tb/tb_wave_gen_cordic_nco.sv
// Scoreboard bench for wave_gen_cordic_nco: a phase-level model pushes the
// expected (channel, cos, sin) of every sample; a negedge monitor pops and
// compares whenever o_valid is seen.
`timescale 1ns/1ps
module tb_wave_gen_cordic_nco;
  localparam int NCH    = 2;
  localparam int PW     = 16;
  localparam int OW     = 16;
  localparam int NITER  = 14;
  localparam int GW     = 2;
  localparam int PI_P   = 25736;
  localparam int PERIOD = NITER + 2;
  localparam int TOL    = 4;

  logic                 clk = 1'b0;
  logic                 rst, en, i_sync;
  logic [NCH*PW-1:0]    i_phi;
  logic signed [OW-1:0] dut_cos, dut_sin;
  logic                 o_valid;
  logic [0:0]           o_ch;

  always #5 clk = ~clk;

  wave_gen_cordic_nco #(.NCH(NCH), .PW(PW), .OW(OW), .NITER(NITER), .GW(GW)) dut (
    .clk(clk), .rst(rst), .en(en), .i_sync(i_sync), .i_phi(i_phi),
    .cos(dut_cos), .sin(dut_sin), .o_valid(o_valid), .o_ch(o_ch)
  );

  typedef struct { int ch; int cs; int sn; bit gap; } exp_t;
  exp_t sb[$];

  int n_vec = 0, n_err = 0, n_seen = 0, cyc = 0, last_cyc = 0;
  int macc[NCH];
  int minc[NCH];
  int mptr;

  task automatic chk(input string nm, input int act, input int exp_v, input int tol);
    n_vec++;
    if (act > exp_v + tol || act < exp_v - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d) at %0t", nm, act, exp_v, tol, $time);
    end
  endtask

  // Raw 16-bit increment pattern -> signed value clamped to [-PI, PI].
  function automatic int sat_inc(input int v);
    int s;
    s = (v >= 32768) ? v - 65536 : v;
    if (s > PI_P) s = PI_P;
    else if (s < -PI_P) s = -PI_P;
    return s;
  endfunction

  function automatic int wrap_ph(input int s);
    if (s > PI_P) return s - 2 * PI_P;
    if (s < -PI_P) return s + 2 * PI_P;
    return s;
  endfunction

  task automatic model_reset;
    for (int c = 0; c < NCH; c++) macc[c] = 0;
    mptr = 0;
  endtask

  // Queue the next n samples in round-robin order from the model phases.
  task automatic push_n(input int n);
    exp_t e;
    real  ang;
    for (int k = 0; k < n; k++) begin
      ang   = real'(macc[mptr]) / 8192.0;
      e.ch  = mptr;
      e.cs  = int'(16384.0 * $cos(ang));
      e.sn  = int'(16384.0 * $sin(ang));
      e.gap = (k > 0);
      sb.push_back(e);
      macc[mptr] = wrap_ph(macc[mptr] + sat_inc(minc[mptr]));
      mptr = (mptr + 1) % NCH;
    end
  endtask

  task automatic set_inc(input int c, input int v);
    minc[c] = v & 32'hFFFF;
    i_phi[c*PW +: PW] = v[PW-1:0];
  endtask

  task automatic wait_seen(input int target);
    int b;
    b = 0;
    while (n_seen < target && b < 200) begin
      @(negedge clk); #1;
      b++;
    end
  endtask

  // Keep en high until the last sample has started, drop it mid-sample and
  // confirm exactly that one further strobe arrives.
  task automatic finish_seg(input int target);
    wait_seen(target - 1);
    @(negedge clk); #1;
    en = 1'b0;
    wait_seen(target);
    chk("samples_seen", n_seen, target, 0);
    repeat (40) @(negedge clk);
  endtask

  task automatic run_seg(input int n);
    int target;
    target = n_seen + n;
    push_n(n);
    en = 1'b1;
    finish_seg(target);
  endtask

  task automatic do_sync;
    @(negedge clk);
    i_sync = 1'b1;
    @(negedge clk);
    i_sync = 1'b0;
    model_reset();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && o_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", int'(o_valid), 0, 0);
      end else begin
        e = sb.pop_front();
        chk("o_ch", int'(o_ch), e.ch, 0);
        chk("cos", int'(dut_cos), e.cs, TOL);
        chk("sin", int'(dut_sin), e.sn, TOL);
        if (e.gap) chk("period", cyc - last_cyc, PERIOD, 0);
      end
      last_cyc = cyc;
      n_seen++;
    end
  end

  initial begin
    int base;
    rst = 1'b1; en = 1'b0; i_sync = 1'b0; i_phi = '0;
    for (int c = 0; c < NCH; c++) minc[c] = 0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_cos", int'(dut_cos), 0, 0);
    chk("rst_sin", int'(dut_sin), 0, 0);
    chk("rst_valid", int'(o_valid), 0, 0);
    chk("rst_ch", int'(o_ch), 0, 0);
    #1 rst = 1'b0;
    @(negedge clk);

    // Zero increments: every sample is phase 0, channels alternate.
    set_inc(0, 0); set_inc(1, 0);
    run_seg(4);

    // Quarter-turn steps on ch0.
    do_sync();
    set_inc(0, 12868); set_inc(1, int'($urandom_range(0, 65535)));
    run_seg(10);

    // 20000-step wraps past +PI without snapping.
    do_sync();
    set_inc(0, 20000); set_inc(1, int'($urandom_range(0, 65535)));
    run_seg(8);

    // Increment saturation at both extremes.
    do_sync();
    set_inc(0, 16'h7FFF); set_inc(1, 3000);
    run_seg(6);
    set_inc(0, 16'h8000);
    run_seg(4);

    // Sync while ch1 is mid-rotation: that sample vanishes, ch0 restarts at 0.
    do_sync();
    set_inc(0, 5000); set_inc(1, 7000);
    base = n_seen;
    push_n(1);
    en = 1'b1;
    wait_seen(base + 1);
    chk("sync_pre_sample", n_seen, base + 1, 0);
    repeat (4) @(negedge clk);
    i_sync = 1'b1;
    @(negedge clk);
    i_sync = 1'b0;
    model_reset();
    base = n_seen;
    push_n(2);
    finish_seg(base + 2);

    // Random increments; accumulators carry over idle gaps.
    for (int r = 0; r < 8; r++) begin
      set_inc(0, int'($urandom_range(0, 65535)));
      set_inc(1, int'($urandom_range(0, 65535)));
      run_seg(int'($urandom_range(1, 7)));
    end

    // Asynchronous reset between clock edges during a rotation.
    base = n_seen;
    push_n(2);
    en = 1'b1;
    wait_seen(base + 1);
    chk("rst_pre_sample", n_seen, base + 1, 0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_cos", int'(dut_cos), 0, 0);
    chk("arst_sin", int'(dut_sin), 0, 0);
    chk("arst_valid", int'(o_valid), 0, 0);
    chk("arst_ch", int'(o_ch), 0, 0);
    sb.delete();
    en = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_seg(3);

    chk("scoreboard_empty", sb.size(), 0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/wave_gen_cordic_nco.md
Name: wave_gen_cordic_nco

Overview:
- Multi-channel numerically controlled oscillator with a built-in iterative rotation-mode CORDIC core.
- Produces sine/cosine samples for NCH independent channels, time-multiplexed round-robin over one shared CORDIC datapath. No vendor IP is used.
- Replaces the single-channel IP-wrapped generator:
  - phase wraps correctly modulo 2π instead of snapping to -π;
  - quadrant folding covers the full ±π range;
  - per-sample output strobe with channel tag;
  - synchronous phase-sync input.
- Sits between the per-channel frequency-control registers and the downstream mixers/DAC formatters.

Parameters:
- NCH, 2, number of channels (≥1).
- PW, 16, phase/increment width; signed fixed point 1.2.(PW-3) radians.
- OW, 16, sin/cos output width; signed fixed point 1.1.(OW-2), so 1.0 = 2^(OW-2).
- NITER, 14, CORDIC micro-rotations per sample (≤ OW).
- GW, 2, internal guard bits on the x/y datapath.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active high
- en  in  1  run enable; sampled in IDLE
- i_sync  in  1  synchronous phase reset; single-cycle pulse
- i_phi  in  NCH*PW  per-channel phase increment; channel c occupies bits [c*PW +: PW]; signed
- cos  out  OW  cosine of the sample phase; signed
- sin  out  OW  sine of the sample phase; signed
- o_valid  out  1  one-cycle strobe; cos/sin/o_ch valid
- o_ch  out  clog2(NCH) (min 1)  channel index of the current output

Behaviour:
- Reset (async, rst=1):
  - all phase accumulators = 0; FSM = IDLE; channel pointer = 0;
  - cos = 0, sin = 0, o_valid = 0, o_ch = 0.
- Constants:
  - PI = round(π·2^(PW-3)) (PW=16: 25736); HALF_PI = round(π/2·2^(PW-3)) (12868).
  - x_init = round(0.6072529350·2^(OW-2+GW)).
  - atan table entry i = round(atan(2^-i)·2^(PW-3)), generated at elaboration.
- FSM: IDLE -> LOAD -> ITER -> DONE -> IDLE.
- IDLE:
  - en=1 -> LOAD next cycle;
  - en=0 -> hold. Pointer and accumulators are retained.
- LOAD (1 cycle), for channel c = pointer:
  - Sample angle a = acc[c].
  - Quadrant fold:
    - a > HALF_PI -> z = a - PI, neg = 1;
    - a < -HALF_PI -> z = a + PI, neg = 1;
    - otherwise z = a, neg = 0.
  - Initialise x = x_init, y = 0, i = 0.
  - Update acc[c] = wrap(acc[c] + inc[c]):
    - inc[c] is first saturated to [-PI, PI];
    - the sum is taken in PW+1 bits;
    - sum > PI -> subtract 2·PI; sum < -PI -> add 2·PI.
- ITER (exactly NITER cycles), per cycle:
  - d = sign(z) (z ≥ 0 -> +1);
  - x -= d·(y>>>i); y += d·(x>>>i); z -= d·atan[i] (all from old values);
  - i++.
- DONE (1 cycle):
  - Apply negation if neg.
  - Drop GW guard bits with round-half-up.
  - Saturate to [-2^(OW-2), +2^(OW-2)].
  - Register cos, sin; o_ch = c; o_valid = 1.
  - Pointer = (c+1) mod NCH.
  - Go to IDLE, or directly to LOAD if en=1.
- Timing with continuous en:
  - one sample every NITER+2 cycles;
  - each channel updates every NCH·(NITER+2) cycles.
  - Latency from the LOAD cycle to o_valid = NITER+1 cycles.
- Output hold: cos/sin/o_ch hold between strobes; o_valid is 0 outside DONE.
- i_phi changes: sampled only in LOAD; changes mid-computation affect the next update of that channel only.
- Starting sample: the first sample of every channel after reset/sync uses phase 0 (cos ≈ +1.0, sin ≈ 0).
- en deasserted mid-sample: the current sample completes and is emitted; the FSM then idles.
- i_sync=1 (any state):
  - next edge: all accumulators = 0, pointer = 0, FSM = IDLE;
  - in-flight sample is aborted, no o_valid that cycle;
  - cos/sin hold. i_sync has priority over en.
- Accuracy: |error| ≤ 4 LSB of OW for all phases at default parameters.

Test Plan:
- Default parameters; reset; en=1; inc0=0, inc1=0 -> o_valid every 16 cycles; o_ch alternates 0,1; every sample cos = 16384±4, sin = 0±4.
- inc0=12868 (π/2) -> ch0 phases 0, π/2, π, -π/2, 0 -> (cos,sin) = (16384,0), (0,16384), (-16384,0), (0,-16384), (16384,0), each ±4.
- inc0=20000 -> ch0 accumulator 0, 20000, -11472 (40000 - 51472), 8528 -> outputs match cos/sin of those angles ±4; no snap to -π.
- Saturation: inc0 = 0x7FFF -> treated as 25736; phase sequence 0, π, 0 (25736 + 25736 - 51472); ch1 is unaffected.
- Pulse i_sync during an ITER cycle of ch1 -> no o_valid for that sample; the next o_valid is ch0 with cos = 16384±4, sin = 0±4.
- Assert rst asynchronously mid-ITER (between clock edges) -> outputs and o_valid are 0 immediately. Deassert en mid-sample -> exactly one more o_valid, then none.
